// File: rtl/modport_fifo.sv
// Single-clock FIFO with registered read data and wrap-bit pointers.
// Flags come straight from the registered pointers, so they describe the state after the last edge.
module modport_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_en,
  input  logic             r_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    waddr, raddr;
  logic             wr_acc, rd_acc;

  assign waddr = wptr_q[AW-1:0];
  assign raddr = rptr_q[AW-1:0];

  // Same address with opposite wrap bits means the writer is one full lap ahead.
  assign empty = (wptr_q == rptr_q);
  assign full  = (waddr == raddr) && (wptr_q[AW] != rptr_q[AW]);

  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    dout_d = dout_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) begin
      rptr_d = rptr_q + 1'b1;
      dout_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[waddr] <= data_in;
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_modport_fifo.sv
// Directed bench for modport_fifo: reset, fill/overflow, underflow, concurrent traffic,
// boundary simultaneity and asynchronous mid-operation reset.
module tb_modport_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  modport_fifo #(.DEPTH(8), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge; inputs change there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    w_en = 1'b1; data_in = d;
    cyc();
    w_en = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got=%b exp=0", full); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_dout got=%h exp=00", data_out); end
    cyc();
    rst = 1'b0;
    push(8'h11);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL rst_wr_empty got=%b exp=0", empty); end
    r_en = 1'b1; cyc(); r_en = 1'b0;
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL rst_rd_data got=%h exp=11", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_rd_empty got=%b exp=1", empty); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      if (i == 7) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_7_full got=%b exp=0", full); end
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    push(8'hFF);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_ovf_full got=%b exp=1", full); end
    r_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      checks++;
      if (data_out !== 8'(i)) begin errors++; $display("FAIL fill_rd%0d got=%h exp=%h", i, data_out, 8'(i)); end
    end
    r_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_notfull got=%b exp=0", full); end
  endtask

  task automatic test_underflow();
    r_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (data_out !== 8'h08) begin errors++; $display("FAIL udf_hold%0d got=%h exp=08", i, data_out); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL udf_empty%0d got=%b exp=1", i, empty); end
    end
    r_en = 1'b0;
    push(8'h5A);
    r_en = 1'b1; cyc(); r_en = 1'b0;
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL udf_after got=%h exp=5a", data_out); end
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    w_en = 1'b1; r_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'hA4 + 8'(i);
      cyc();
      checks++;
      if (data_out !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL conc_rd%0d got=%h exp=%h", i, data_out, 8'hA0 + 8'(i)); end
      checks++;
      if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL conc_flags%0d got=e%b f%b exp=e0 f0", i, empty, full); end
    end
    w_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (data_out !== 8'hAA + 8'(i)) begin errors++; $display("FAIL conc_drain%0d got=%h exp=%h", i, data_out, 8'hAA + 8'(i)); end
    end
    r_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL conc_empty got=%b exp=1", empty); end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL bnd_full got=%b exp=1", full); end
    w_en = 1'b1; r_en = 1'b1; data_in = 8'hEE;
    cyc();
    w_en = 1'b0;
    checks++; if (data_out !== 8'hC0) begin errors++; $display("FAIL bnd_full_rd got=%h exp=c0", data_out); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL bnd_full_after got=%b exp=0", full); end
    // If 0xEE had been accepted it would surface after C7 instead of empty.
    for (int i = 1; i < 8; i++) begin
      cyc();
      checks++;
      if (data_out !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL bnd_drain%0d got=%h exp=%h", i, data_out, 8'hC0 + 8'(i)); end
    end
    r_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bnd_drop_empty got=%b exp=1", empty); end
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h77;
    cyc();
    w_en = 1'b0; r_en = 1'b0;
    checks++; if (data_out !== 8'hC7) begin errors++; $display("FAIL bnd_empty_hold got=%h exp=c7", data_out); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL bnd_empty_after got=%b exp=0", empty); end
    r_en = 1'b1; cyc(); r_en = 1'b0;
    checks++; if (data_out !== 8'h77) begin errors++; $display("FAIL bnd_empty_rd got=%h exp=77", data_out); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) push(8'hD0 + 8'(i));
    r_en = 1'b1; cyc(); r_en = 1'b0;
    checks++; if (data_out !== 8'hD0) begin errors++; $display("FAIL mrst_pre got=%h exp=d0", data_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mrst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL mrst_full got=%b exp=0", full); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mrst_dout got=%h exp=00", data_out); end
    #1 rst = 1'b0;
    cyc();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mrst_stays_empty got=%b exp=1", empty); end
    for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL mrst_refill got=%b exp=1", full); end
    r_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++;
      if (data_out !== 8'hB0 + 8'(i)) begin errors++; $display("FAIL mrst_rd%0d got=%h exp=%h", i, data_out, 8'hB0 + 8'(i)); end
    end
    r_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mrst_end_empty got=%b exp=1", empty); end
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
    test_reset();
    test_fill();
    test_underflow();
    test_concurrent();
    test_boundary();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
